// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and byte-enable helper for the data_ram_pipe data memory.
package dmem_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RD_WAIT = 2'b01,
      RESP    = 2'b10
   } state_t;

   function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] addr_lo);
      logic [3:0] be;
      case (size)
         SIZE_BYTE: be = 4'b0001 << addr_lo;
         SIZE_HALF: be = 4'b0011 << addr_lo;
         SIZE_WORD: be = 4'b1111;
         default:   be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/data_ram_pipe_if.sv
// Request/response bus between the CPU load/store unit (master) and data_ram_pipe (slave).
interface data_ram_pipe_if #(
   parameter int ADDR_W = 7
) ();

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_sext;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_we, req_size, req_sext, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: store data replication, misalignment check, and load shift with extension.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_addr_lo,
   input  logic [31:0] st_wdata,
   output logic [31:0] st_lanes,
   output logic        st_err,
   input  logic [1:0]  ld_size,
   input  logic [1:0]  ld_addr_lo,
   input  logic        ld_sext,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [31:0] shifted_s;

   assign shifted_s = ld_word >> {ld_addr_lo, 3'b000};

   // store lane replication and request legality
   always_comb begin
      st_lanes = 32'd0;
      st_err   = 1'b1;
      case (st_size)
         SIZE_BYTE: begin
            st_lanes = {4{st_wdata[7:0]}};
            st_err   = 1'b0;
         end
         SIZE_HALF: begin
            st_lanes = {2{st_wdata[15:0]}};
            st_err   = st_addr_lo[0];
         end
         SIZE_WORD: begin
            st_lanes = st_wdata;
            st_err   = (st_addr_lo != 2'b00);
         end
         default: begin
            st_lanes = 32'd0;
            st_err   = 1'b1;
         end
      endcase
   end

   // load right-alignment with sign or zero fill
   always_comb begin
      ld_data = shifted_s;
      case (ld_size)
         SIZE_BYTE: ld_data = {{24{ld_sext & shifted_s[7]}}, shifted_s[7:0]};
         SIZE_HALF: ld_data = {{16{ld_sext & shifted_s[15]}}, shifted_s[15:0]};
         SIZE_WORD: ld_data = shifted_s;
         default:   ld_data = 32'd0;
      endcase
   end

endmodule

// File: rtl/data_ram_pipe.sv
// Byte-addressable 32-bit data memory with valid/ready handshake and READ_LAT-cycle loads.
// Define DMEM_TEST_PORT_EN to add the combinational test_addr/test_data debug read port.
module data_ram_pipe
   import dmem_pkg::*;
#(
   parameter int ADDR_W   = 7,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
`ifdef DMEM_TEST_PORT_EN
   input  logic [ADDR_W-3:0] test_addr,
   output logic [31:0]       test_data,
`endif
   data_ram_pipe_if.slave    bus
);

   localparam int         DEPTH    = 2 ** (ADDR_W - 2);
   localparam logic [2:0] LAT_LAST = 3'(READ_LAT - 1);

   logic [31:0]       mem [DEPTH];
   state_t            state_r;
   state_t            next_state_s;
   logic [2:0]        lat_cnt_r;
   logic [1:0]        size_r;
   logic [1:0]        addr_lo_r;
   logic              sext_r;
   logic              load_ok_r;
   logic              err_r;
   logic [31:0]       rd_word_r;
   logic              accept_s;
   logic              req_err_s;
   logic [31:0]       st_lanes_s;
   logic [31:0]       ld_data_s;
   logic [3:0]        be_s;
   logic [ADDR_W-3:0] word_idx_s;

   assign accept_s   = bus.req_valid & bus.req_ready & ~rst;
   assign word_idx_s = bus.req_addr[ADDR_W-1:2];
   assign be_s       = be_gen(bus.req_size, bus.req_addr[1:0]);

   dmem_lane_align u_align (
      .st_size    (bus.req_size),
      .st_addr_lo (bus.req_addr[1:0]),
      .st_wdata   (bus.req_wdata),
      .st_lanes   (st_lanes_s),
      .st_err     (req_err_s),
      .ld_size    (size_r),
      .ld_addr_lo (addr_lo_r),
      .ld_sext    (sext_r),
      .ld_word    (rd_word_r),
      .ld_data    (ld_data_s)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_r <= IDLE;
      else     state_r <= next_state_s;
   end

   // next state; with READ_LAT==1 the synchronous read alone supplies the latency, so RD_WAIT is skipped
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (!bus.req_we && !req_err_s && (READ_LAT > 1)) next_state_s = RD_WAIT;
               else                                             next_state_s = RESP;
            end else begin
               next_state_s = IDLE;
            end
         end
         RD_WAIT: begin
            if (lat_cnt_r == LAT_LAST) next_state_s = RESP;
            else                       next_state_s = RD_WAIT;
         end
         RESP: begin
            if (bus.resp_ready) next_state_s = IDLE;
            else                next_state_s = RESP;
         end
         default: next_state_s = IDLE;
      endcase
   end

   // latency counter: holds the number of cycles elapsed since accept while waiting
   always_ff @(posedge clk) begin
      if (rst)                     lat_cnt_r <= 3'd0;
      else if (accept_s)           lat_cnt_r <= 3'd1;
      else if (state_r == RD_WAIT) lat_cnt_r <= lat_cnt_r + 3'd1;
      else                         lat_cnt_r <= lat_cnt_r;
   end

   // request fields captured on accept so the master may move on
   always_ff @(posedge clk) begin
      if (rst) begin
         size_r    <= SIZE_BYTE;
         addr_lo_r <= 2'b00;
         sext_r    <= 1'b0;
         load_ok_r <= 1'b0;
         err_r     <= 1'b0;
      end else if (accept_s) begin
         size_r    <= bus.req_size;
         addr_lo_r <= bus.req_addr[1:0];
         sext_r    <= bus.req_sext;
         load_ok_r <= ~bus.req_we & ~req_err_s;
         err_r     <= req_err_s;
      end
   end

   // storage: byte-lane write and synchronous read on accept; unreset so contents survive rst
   always_ff @(posedge clk) begin
      if (accept_s) begin
         if (bus.req_we && !req_err_s) begin
            for (int i = 0; i < 4; i++) begin
               if (be_s[i]) mem[word_idx_s][8*i +: 8] <= st_lanes_s[8*i +: 8];
            end
         end
         rd_word_r <= mem[word_idx_s];
      end
   end

   assign bus.req_ready  = (state_r == IDLE);
   assign bus.resp_valid = (state_r == RESP);
   assign bus.resp_err   = (state_r == RESP) & err_r;
   assign bus.resp_rdata = ((state_r == RESP) && load_ok_r) ? ld_data_s : 32'd0;

`ifdef DMEM_TEST_PORT_EN
   assign test_data = mem[test_addr];
`endif

endmodule

// File: tb/tb_data_ram_pipe.sv
// Self-checking bench for data_ram_pipe: directed and randomized loads/stores against a byte-array model.
// Build with DMEM_TEST_PORT_EN defined to also exercise the debug read port.
module tb_data_ram_pipe;

   localparam int ADDR_W   = 7;
   localparam int READ_LAT = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   data_ram_pipe_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef DMEM_TEST_PORT_EN
   logic [ADDR_W-3:0] test_addr;
   logic [31:0]       test_data;
   logic              pin31 = 1'b0;
`endif

   int          n_checks  = 0;
   int          n_pass    = 0;
   int          cyc       = 0;
   logic        pend      = 1'b0;
   int          due       = 0;
   logic [31:0] exp_rdata = 32'd0;
   logic        exp_err   = 1'b0;
   logic        run       = 1'b0;
   logic        init_done = 1'b0;
   logic [7:0]  mem_m [0:127];

`ifdef DMEM_TEST_PORT_EN
   assign test_addr = pin31 ? 5'd31 : 5'(cyc);
`endif

   data_ram_pipe #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef DMEM_TEST_PORT_EN
      .test_addr (test_addr),
      .test_data (test_data),
`endif
      .bus       (bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b, expected %b", name, act, exp);
   endtask

   function automatic logic model_err(input logic [1:0] size, input int a);
      return (size == 2'd3) || (size == 2'd1 && (a % 2) != 0) || (size == 2'd2 && (a % 4) != 0);
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] size, input logic sext, input int a);
      logic [31:0] v;
      case (size)
         2'd0: begin
            v = {24'd0, mem_m[a]};
            if (sext && mem_m[a][7]) v = v | 32'hFFFF_FF00;
         end
         2'd1: begin
            v = {16'd0, mem_m[a+1], mem_m[a]};
            if (sext && mem_m[a+1][7]) v = v | 32'hFFFF_0000;
         end
         default: v = {mem_m[a+3], mem_m[a+2], mem_m[a+1], mem_m[a]};
      endcase
      return v;
   endfunction

   function automatic logic [31:0] model_word(input int w);
      return {mem_m[4*w+3], mem_m[4*w+2], mem_m[4*w+1], mem_m[4*w]};
   endfunction

   // Model: accept when idle, apply stores to the byte array, schedule the expected response
   always @(posedge clk) begin
      int a;
      cyc <= cyc + 1;
      if (rst) begin
         pend <= 1'b0;
      end else if (pend) begin
         if (cyc >= due && bus.resp_ready) pend <= 1'b0;
      end else if (bus.req_valid) begin
         a = int'(bus.req_addr);
         pend    <= 1'b1;
         exp_err <= model_err(bus.req_size, a);
         if (model_err(bus.req_size, a)) begin
            due       <= cyc + 1;
            exp_rdata <= 32'd0;
         end else if (bus.req_we) begin
            due       <= cyc + 1;
            exp_rdata <= 32'd0;
            for (int i = 0; i < (1 << bus.req_size); i++) mem_m[a+i] <= bus.req_wdata[8*i +: 8];
         end else begin
            due       <= cyc + READ_LAT;
            exp_rdata <= model_load(bus.req_size, bus.req_sext, a);
         end
      end
   end

   // Compare DUT outputs with the model every cycle outside reset
   always @(negedge clk) begin
      if (run && !rst) begin
         chk1("req_ready", bus.req_ready, !pend);
         if (pend && cyc >= due) begin
            chk1("resp_valid", bus.resp_valid, 1'b1);
            chk("resp_rdata", bus.resp_rdata, exp_rdata);
            chk1("resp_err", bus.resp_err, exp_err);
         end else begin
            chk1("resp_valid_quiet", bus.resp_valid, 1'b0);
         end
`ifdef DMEM_TEST_PORT_EN
         if (init_done) chk("test_data", test_data, model_word(int'(test_addr)));
`endif
      end
   end

   task automatic xact(input logic we, input logic [1:0] size, input logic sext, input logic [6:0] addr,
                       input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output logic er, output int lat);
      int k;
      k = 0;
      while (pend && k < 60) begin
         @(posedge clk); #1;
         k++;
      end
      chk1("idle_wait", pend, 1'b0);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_size  = size;
      bus.req_sext  = sext;
      bus.req_addr  = addr;
      bus.req_wdata = wd;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'($urandom);
      bus.req_size  = 2'($urandom);
      bus.req_sext  = 1'($urandom);
      bus.req_addr  = 7'($urandom);
      bus.req_wdata = $urandom;
      lat = 0;
      while (lat < 12) begin
         @(negedge clk);
         lat++;
         if (bus.resp_valid) break;
      end
      chk1("resp_seen", bus.resp_valid, 1'b1);
      rd = bus.resp_rdata;
      er = bus.resp_err;
      repeat (hold) @(negedge clk);
      @(posedge clk); #1;
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      logic [1:0]  sz;
      logic [6:0]  a;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_size   = 2'd0;
      bus.req_sext   = 1'b0;
      bus.req_addr   = 7'd0;
      bus.req_wdata  = 32'd0;
      bus.resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      run = 1'b1;
      @(negedge clk);
      chk1("rst_resp_valid", bus.resp_valid, 1'b0);
      chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
      chk1("rst_resp_err", bus.resp_err, 1'b0);
      chk1("rst_req_ready", bus.req_ready, 1'b1);
      @(posedge clk); #1;

      for (int w = 0; w < 32; w++) xact(1'b1, 2'd2, 1'b0, 7'(w * 4), $urandom, 0, rd, er, lat);
      init_done = 1'b1;

      // word store then load
      xact(1'b1, 2'd2, 1'b0, 7'h04, 32'h1234_5678, 0, rd, er, lat);
      chk1("t1_store_err", er, 1'b0);
      chk("t1_store_rdata", rd, 32'd0);
      xact(1'b0, 2'd2, 1'b0, 7'h04, 32'd0, 0, rd, er, lat);
      chk("t1_load", rd, 32'h1234_5678);
      chk1("t1_load_err", er, 1'b0);
      chk("t1_latency", 32'(lat), 32'(READ_LAT));

      // byte store, signed/unsigned byte loads, merged word
      xact(1'b1, 2'd0, 1'b0, 7'h05, 32'h5566_77AB, 0, rd, er, lat);
      xact(1'b0, 2'd0, 1'b1, 7'h05, 32'd0, 0, rd, er, lat);
      chk("t2_lb_signed", rd, 32'hFFFF_FFAB);
      xact(1'b0, 2'd0, 1'b0, 7'h05, 32'd0, 0, rd, er, lat);
      chk("t2_lb_unsigned", rd, 32'h0000_00AB);
      xact(1'b0, 2'd2, 1'b0, 7'h04, 32'd0, 0, rd, er, lat);
      chk("t2_word_merge", rd, 32'h1234_AB78);
      xact(1'b0, 2'd1, 1'b1, 7'h06, 32'd0, 0, rd, er, lat);
      chk("t2_lh_signed", rd, 32'h0000_1234);

      // misaligned and illegal requests
      xact(1'b0, 2'd1, 1'b1, 7'h03, 32'd0, 0, rd, er, lat);
      chk1("t3_half_err", er, 1'b1);
      chk("t3_half_rdata", rd, 32'd0);
      xact(1'b1, 2'd2, 1'b0, 7'h06, 32'hCAFE_F00D, 0, rd, er, lat);
      chk1("t3_store_err", er, 1'b1);
      chk("t3_store_latency", 32'(lat), 32'd1);
      xact(1'b0, 2'd3, 1'b0, 7'h04, 32'd0, 0, rd, er, lat);
      chk1("t3_size11_err", er, 1'b1);
      xact(1'b0, 2'd2, 1'b0, 7'h04, 32'd0, 0, rd, er, lat);
      chk("t3_mem_unchanged", rd, 32'h1234_AB78);

      // response back-pressure
      xact(1'b0, 2'd2, 1'b0, 7'h04, 32'd0, 5, rd, er, lat);
      chk("t4_held_rdata", rd, 32'h1234_AB78);
      @(negedge clk);
      chk1("t4_idle_after", bus.req_ready, 1'b1);
      @(posedge clk); #1;

      // reset one cycle after a load accept discards the response
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_size  = 2'd2;
      bus.req_addr  = 7'h04;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < READ_LAT + 2; i++) begin
         @(negedge clk);
         chk1("t5_no_resp", bus.resp_valid, 1'b0);
      end
      chk1("t5_ready", bus.req_ready, 1'b1);
      @(posedge clk); #1;

`ifdef DMEM_TEST_PORT_EN
      pin31 = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_size  = 2'd2;
      bus.req_addr  = 7'h7C;
      bus.req_wdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("t6_test_data", test_data, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
      pin31 = 1'b0;
`endif

      for (int n = 0; n < 200; n++) begin
         sz = 2'($urandom_range(3, 0));
         a  = 7'($urandom);
         if ($urandom_range(9, 0) < 7) begin
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
         end
         xact(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(2, 0), rd, er, lat);
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
